cpu_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/cpu_sequencer_decode.sv | 61 ++++++
 rtl/cpu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU sequencer: states, opcode/ext fields,
// datapath mux selects and the instruction class produced by the decoder.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEMRD  = 3'd3,
        ST_MEMWR  = 3'd4,
        ST_LDWB   = 3'd5,
        ST_BRANCH = 3'd6,
        ST_JAL    = 3'd7
    } state_e;

    // R-type ext codes double as the immediate-form opcodes
    localparam logic [FIELD_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [FIELD_W-1:0] OP_MEM   = 4'b0100;
    localparam logic [FIELD_W-1:0] OP_BCOND = 4'b1100;
    localparam logic [FIELD_W-1:0] OPC_ADD  = 4'b0101;
    localparam logic [FIELD_W-1:0] OPC_SUB  = 4'b1001;
    localparam logic [FIELD_W-1:0] OPC_CMP  = 4'b1011;
    localparam logic [FIELD_W-1:0] OPC_AND  = 4'b0001;
    localparam logic [FIELD_W-1:0] OPC_OR   = 4'b0010;
    localparam logic [FIELD_W-1:0] OPC_XOR  = 4'b0011;
    localparam logic [FIELD_W-1:0] OPC_MOV  = 4'b1101;
    localparam logic [FIELD_W-1:0] OPC_LSH  = 4'b1000;
    localparam logic [FIELD_W-1:0] OPC_LUI  = 4'b1111;
    localparam logic [FIELD_W-1:0] EXT_NOP  = 4'b0000;

    localparam logic [FIELD_W-1:0] EXT_LOAD  = 4'b0000;
    localparam logic [FIELD_W-1:0] EXT_STOR  = 4'b0100;
    localparam logic [FIELD_W-1:0] EXT_JAL   = 4'b1000;
    localparam logic [FIELD_W-1:0] EXT_JCOND = 4'b1100;

    localparam logic [1:0] PC_SRC_INC  = 2'd0;
    localparam logic [1:0] PC_SRC_DISP = 2'd1;
    localparam logic [1:0] PC_SRC_REG  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STOR,
        CL_BRANCH,
        CL_JAL,
        CL_NOP,
        CL_ILLEGAL
    } iclass_e;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       ir_en;
        logic       mem_re;
        logic       mem_we;
        logic       addr_sel;
        logic       alu_en;
        logic       psr_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational instruction classifier: maps IR opcode/ext to an instruction
// class plus register-write, PSR-write and branch-target flags.
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output iclass_e            o_class,
    output logic               o_writes_reg,
    output logic               o_writes_psr,
    output logic               o_branch_reg
);

    logic [FIELD_W-1:0] w_op;
    logic [FIELD_W-1:0] w_ext;
    logic               w_unused;

    assign w_op     = i_instr[15:12];
    assign w_ext    = i_instr[7:4];
    assign w_unused = ^{i_instr[11:8], i_instr[3:0]};

    always_comb begin
        o_class      = CL_ILLEGAL;
        o_writes_reg = 1'b0;
        o_writes_psr = 1'b0;
        o_branch_reg = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                if (w_ext == EXT_NOP) begin
                    o_class = CL_NOP;
                end else begin
                    o_class      = CL_ALU;
                    o_writes_reg = (w_ext != OPC_CMP);
                    o_writes_psr = (w_ext == OPC_ADD) || (w_ext == OPC_SUB) ||
                                   (w_ext == OPC_CMP);
                end
            end
            OPC_ADD, OPC_SUB, OPC_CMP, OPC_AND, OPC_OR, OPC_XOR,
            OPC_MOV, OPC_LSH, OPC_LUI: begin
                o_class      = CL_ALU;
                o_writes_reg = (w_op != OPC_CMP);
                o_writes_psr = (w_op == OPC_ADD) || (w_op == OPC_SUB) ||
                               (w_op == OPC_CMP);
            end
            OP_MEM: begin
                case (w_ext)
                    EXT_LOAD:  o_class = CL_LOAD;
                    EXT_STOR:  o_class = CL_STOR;
                    EXT_JAL:   o_class = CL_JAL;
                    EXT_JCOND: begin
                        o_class      = CL_BRANCH;
                        o_branch_reg = 1'b1;
                    end
                    default:   o_class = CL_ILLEGAL;
                endcase
            end
            OP_BCOND: o_class = CL_BRANCH;
            default:  o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory access and
// branch/jump for the shared datapath, with a mem_ready stall timeout.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [1:0]  RESET_PC_SEL = 2'd0,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    input  logic               cond_true,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               ir_en,
    output logic               mem_re,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               alu_en,
    output logic               psr_we,
    output logic               reg_we,
    output logic [1:0]         wb_sel,
    output logic [2:0]         state,
    output logic               illegal
);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_first;
    ctrl_t              w_ctrl;
    iclass_e            w_class;
    logic               w_writes_reg;
    logic               w_writes_psr;
    logic               w_branch_reg;
    logic               w_wait;
    logic               w_timeout;

    instr_class_decode u_decode (
        .i_instr      (instr),
        .o_class      (w_class),
        .o_writes_reg (w_writes_reg),
        .o_writes_psr (w_writes_psr),
        .o_branch_reg (w_branch_reg)
    );

    assign w_wait    = (r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                       (r_state == ST_MEMWR);
    assign w_timeout = w_wait && !mem_ready && (r_cnt == CNT_W'(MEM_TIMEOUT));

    // State, stall counter and first-fetch-after-reset flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_cnt   <= '0;
            r_first <= 1'b1;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || mem_ready || w_timeout || !w_wait) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_FETCH) && mem_ready) begin
                r_first <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_re = 1'b1;
                if (mem_ready) begin
                    w_ctrl.ir_en  = 1'b1;
                    w_ctrl.pc_en  = 1'b1;
                    w_ctrl.pc_src = r_first ? RESET_PC_SEL : PC_SRC_INC;
                    w_next        = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_class)
                    CL_ALU:    w_next = ST_EXEC;
                    CL_LOAD:   w_next = ST_MEMRD;
                    CL_STOR:   w_next = ST_MEMWR;
                    CL_BRANCH: w_next = ST_BRANCH;
                    CL_JAL:    w_next = ST_JAL;
                    CL_NOP:    w_next = ST_FETCH;
                    default: begin
                        w_ctrl.illegal = 1'b1;
                        w_next         = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: begin
                w_ctrl.alu_en = 1'b1;
                w_ctrl.wb_sel = WB_ALU;
                w_ctrl.reg_we = w_writes_reg;
                w_ctrl.psr_we = w_writes_psr;
                w_next        = ST_FETCH;
            end
            ST_MEMRD: begin
                w_ctrl.mem_re   = 1'b1;
                w_ctrl.addr_sel = 1'b1;
                if (mem_ready) begin
                    w_next = ST_LDWB;
                end
            end
            ST_LDWB: begin
                w_ctrl.reg_we = 1'b1;
                w_ctrl.wb_sel = WB_MEM;
                w_next        = ST_FETCH;
            end
            ST_MEMWR: begin
                w_ctrl.mem_we   = 1'b1;
                w_ctrl.addr_sel = 1'b1;
                if (mem_ready) begin
                    w_next = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                if (cond_true) begin
                    w_ctrl.pc_en  = 1'b1;
                    w_ctrl.pc_src = w_branch_reg ? PC_SRC_REG : PC_SRC_DISP;
                end
                w_next = ST_FETCH;
            end
            ST_JAL: begin
                w_ctrl.reg_we = 1'b1;
                w_ctrl.wb_sel = WB_LINK;
                w_ctrl.pc_en  = 1'b1;
                w_ctrl.pc_src = PC_SRC_REG;
                w_next        = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
        // A stalled access that times out issues nothing but the illegal pulse
        if (w_timeout) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
            w_next         = ST_FETCH;
        end
        // Reset drops any in-flight request so memory never sees a write
        if (reset) begin
            w_ctrl = '0;
        end
    end

    assign pc_en    = w_ctrl.pc_en;
    assign pc_src   = w_ctrl.pc_src;
    assign ir_en    = w_ctrl.ir_en;
    assign mem_re   = w_ctrl.mem_re;
    assign mem_we   = w_ctrl.mem_we;
    assign addr_sel = w_ctrl.addr_sel;
    assign alu_en   = w_ctrl.alu_en;
    assign psr_we   = w_ctrl.psr_we;
    assign reg_we   = w_ctrl.reg_we;
    assign wb_sel   = w_ctrl.wb_sel;
    assign illegal  = w_ctrl.illegal;
    assign state    = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: walks each instruction class
// cycle by cycle against hand-computed state/control vectors.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        mem_ready;
    logic        cond_true;
    logic        pc_en;
    logic [1:0]  pc_src;
    logic        ir_en;
    logic        mem_re;
    logic        mem_we;
    logic        addr_sel;
    logic        alu_en;
    logic        psr_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        illegal;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;

    cpu_sequencer #(.RESET_PC_SEL(2'd0), .MEM_TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .mem_ready (mem_ready),
        .cond_true (cond_true),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .ir_en     (ir_en),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .alu_en    (alu_en),
        .psr_we    (psr_we),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .state     (state),
        .illegal   (illegal)
    );

    assign obs = {state, pc_en, pc_src, ir_en, mem_re, mem_we, addr_sel,
                  alu_en, psr_we, reg_we, wb_sel, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Expected {state, pc_en, pc_src, ir_en, mem_re, mem_we, addr_sel, alu_en, psr_we, reg_we, wb_sel, illegal}
    function automatic logic [15:0] mk(input logic [2:0] st, input logic pce,
                                       input logic [1:0] pcs, input logic ire,
                                       input logic re, input logic we,
                                       input logic as, input logic alu,
                                       input logic psr, input logic rwe,
                                       input logic [1:0] wb, input logic ill);
        return {st, pce, pcs, ire, re, we, as, alu, psr, rwe, wb, ill};
    endfunction

    logic [15:0] F_RDY, F_WAIT, DEC;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        instr     = 16'h0000;
        mem_ready = 1'b0;
        cond_true = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (obs !== F_WAIT) begin
            $display("FAIL reset_state got=%h want=%h", obs, F_WAIT);
            bad++;
        end
        tick();
    endtask

    task automatic test_add();
        logic [15:0] exp [3];
        exp = '{F_RDY, DEC, mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 1, 1, 1, 2'd0, 0)};
        instr     = 16'h0152;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL add cyc%0d got=%h want=%h", i, obs, exp[i]);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_cmpi_andi();
        logic [15:0] ins [6];
        logic [15:0] exp [6];
        ins = '{16'hB105, 16'hB105, 16'hB105, 16'h1105, 16'h1105, 16'h1105};
        exp = '{F_RDY, DEC, mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 0),
                F_RDY, DEC, mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 0)};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            instr = ins[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL cmpi_andi cyc%0d got=%h want=%h", i, obs, exp[i]);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic        rdy [7];
        logic [15:0] exp [7];
        logic [15:0] rd;
        rd  = mk(3'd3, 0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 0);
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{F_RDY, DEC, rd, rd, rd, rd,
                mk(3'd5, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0)};
        instr = 16'h4102;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL load cyc%0d got=%h want=%h", i, obs, exp[i]);
                bad++;
            end
            tick();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_bcond();
        logic        cnd [6];
        logic [15:0] exp [6];
        cnd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp = '{F_RDY, DEC, mk(3'd6, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0),
                F_RDY, DEC, mk(3'd6, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)};
        instr     = 16'hC1FE;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cond_true = cnd[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL bcond cyc%0d got=%h want=%h", i, obs, exp[i]);
                bad++;
            end
            tick();
        end
        cond_true = 1'b0;
    endtask

    task automatic test_jal();
        logic [15:0] exp [4];
        exp = '{F_RDY, DEC, mk(3'd7, 1, 2'd2, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0), F_RDY};
        instr     = 16'h4E83;
        mem_ready = 1'b1;
        cond_true = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL jal cyc%0d got=%h want=%h", i, obs, exp[i]);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_nop_illegal();
        logic [15:0] ins [4];
        logic [15:0] exp [4];
        ins = '{16'h0000, 16'h0000, 16'h6000, 16'h6000};
        exp = '{F_RDY, DEC, F_RDY, mk(3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1)};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = ins[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL nop_illegal cyc%0d got=%h want=%h", i, obs, exp[i]);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_stor_timeout();
        logic [15:0] e;
        instr = 16'h4142;
        for (int i = 0; i < 19; i++) begin
            mem_ready = (i == 0);
            if (i == 0)       e = F_RDY;
            else if (i == 1)  e = DEC;
            else if (i < 17)  e = mk(3'd4, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 0);
            else if (i == 17) e = mk(3'd4, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1);
            else              e = F_WAIT;
            #1;
            total++;
            if (obs !== e) begin
                $display("FAIL stor_timeout cyc%0d got=%h want=%h", i, obs, e);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_reset_memwr();
        logic [15:0] wr;
        wr        = mk(3'd4, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 0);
        instr     = 16'h4142;
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== F_RDY) begin
            $display("FAIL rst_memwr fetch got=%h want=%h", obs, F_RDY);
            bad++;
        end
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        total++;
        if (obs !== wr) begin
            $display("FAIL rst_memwr write got=%h want=%h", obs, wr);
            bad++;
        end
        tick();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0) begin
            $display("FAIL rst_memwr we_in_reset got=%b want=0", mem_we);
            bad++;
        end
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        total++;
        if (obs !== F_WAIT) begin
            $display("FAIL rst_memwr after_reset got=%h want=%h", obs, F_WAIT);
            bad++;
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== F_RDY) begin
            $display("FAIL rst_memwr first_fetch got=%h want=%h", obs, F_RDY);
            bad++;
        end
        tick();
        total++;
        if (state !== 3'd1) begin
            $display("FAIL rst_memwr decode got=%0d want=1", state);
            bad++;
        end
    endtask

    initial begin
        F_RDY  = mk(3'd0, 1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0);
        F_WAIT = mk(3'd0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0);
        DEC    = mk(3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        test_reset();
        test_add();
        test_cmpi_andi();
        test_load();
        test_bcond();
        test_jal();
        test_nop_illegal();
        test_stor_timeout();
        test_reset_memwr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
